aim_servo_ctrl: RTL and testbench

Consumes the red tracker's per-frame aim result (aim_x, aim_y, aim_detected, target_off) and drives the pan/tilt hobby servos that point the camera. Once per video frame it moves the pan/tilt pulse widths toward the screen centre, using a proportional step with a deadband and saturation. It holds position on short target loss and sweeps pan after the 3 s target_off timeout. Two 50 Hz PWM outputs go to the servo headers.

---
 rtl/aim_servo_pkg.sv | 29 ++
 rtl/servo_pwm_gen.sv | 29 ++
 rtl/aim_servo_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_aim_servo_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aim_servo_pkg.sv
// rtl/aim_servo_pkg.sv - shared types, default timing and clamp helper for the aim servo controller
package aim_servo_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    TRACK  = 2'd1,
    SEARCH = 2'd2
  } servo_state_e;

  localparam int DEF_PWM_PERIOD   = 500000;
  localparam int DEF_PULSE_MIN    = 25000;
  localparam int DEF_PULSE_MAX    = 50000;
  localparam int DEF_PULSE_CENTER = 37500;

  // Adds a signed delta to a pulse width and clamps the result into [lo, hi].
  function automatic logic [15:0] sat_add(
    input logic signed [17:0] base,
    input logic signed [17:0] delta,
    input logic signed [17:0] lo,
    input logic signed [17:0] hi
  );
    logic signed [17:0] sum;
    sum = base + delta;
    if (sum < lo) return 16'(lo);
    if (sum > hi) return 16'(hi);
    return 16'(sum);
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - PWM comparator with width latched at period wrap
module servo_pwm_gen #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic [15:0]      i_width,
  output logic             o_pwm
);

  logic [15:0] r_active;
  logic        r_pwm;

  // Width only changes at the period boundary so a pulse is never truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 16'd0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wrap) r_active <= i_width;
      r_pwm <= (32'(i_cnt) < 32'(r_active));
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/aim_servo_ctrl.sv
// rtl/aim_servo_ctrl.sv - per-frame pan/tilt servo aiming with tracking, hold and sweep search
module aim_servo_ctrl
  import aim_servo_pkg::*;
#(
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int PULSE_MIN    = DEF_PULSE_MIN,
  parameter int PULSE_MAX    = DEF_PULSE_MAX,
  parameter int PULSE_CENTER = DEF_PULSE_CENTER,
  parameter int SCREEN_CX    = 320,
  parameter int SCREEN_CY    = 240,
  parameter int DEADBAND     = 16,
  parameter int GAIN_SHIFT   = 2,
  parameter int MAX_STEP     = 500,
  parameter int SWEEP_STEP   = 250,
  parameter bit PAN_INV      = 1'b0,
  parameter bit TILT_INV     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        v_sync,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        aim_detected,
  input  logic        target_off,
  output logic        pan_pwm,
  output logic        tilt_pwm,
  output logic [15:0] pan_pulse,
  output logic [15:0] tilt_pulse,
  output logic [1:0]  state_out,
  output logic        on_target
);

  localparam int CNT_W = $clog2(PWM_PERIOD);
  localparam logic signed [17:0] L_MIN      = 18'(PULSE_MIN);
  localparam logic signed [17:0] L_MAX      = 18'(PULSE_MAX);
  localparam logic signed [17:0] L_CENTER   = 18'(PULSE_CENTER);
  localparam logic signed [17:0] L_STEP_MAX = 18'(MAX_STEP);
  localparam logic signed [17:0] L_SWEEP    = 18'(SWEEP_STEP);
  localparam logic signed [10:0] L_CX       = 11'(SCREEN_CX);
  localparam logic signed [10:0] L_CY       = 11'(SCREEN_CY);
  localparam logic [10:0]        L_DB       = 11'(DEADBAND);

  logic             r_vsync_d;
  logic             w_tick;
  servo_state_e     r_state;
  servo_state_e     w_state_next;
  logic [15:0]      r_pan;
  logic [15:0]      r_tilt;
  logic             r_dir_up;
  logic             r_on_target;
  logic [15:0]      w_pan_next;
  logic [15:0]      w_tilt_next;
  logic             w_dir_up_next;
  logic             w_on_next;
  logic signed [10:0] w_ex;
  logic signed [10:0] w_ey;
  logic             w_db_x;
  logic             w_db_y;
  logic signed [17:0] w_pan_s;
  logic signed [17:0] w_tilt_s;
  logic signed [17:0] w_sweep_sum;
  logic signed [17:0] w_tdiff;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  function automatic logic [10:0] abs11(input logic signed [10:0] e);
    return e[10] ? 11'(-e) : 11'(e);
  endfunction

  // Proportional step toward the setpoint for one axis; deadband yields no motion.
  function automatic logic [15:0] track_axis(
    input logic [15:0]        pulse,
    input logic signed [10:0] err,
    input logic               inv
  );
    logic [10:0]        mag;
    logic signed [17:0] step;
    logic               up;
    mag  = abs11(err);
    step = 18'(mag) << GAIN_SHIFT;
    if (step > L_STEP_MAX) step = L_STEP_MAX;
    up = (!err[10] && (err != 11'sd0)) ^ inv;
    if (mag <= L_DB) return pulse;
    return sat_add($signed({2'b00, pulse}), up ? step : -step, L_MIN, L_MAX);
  endfunction

  // v_sync_d resets high so the first cycle out of reset cannot produce a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vsync_d <= 1'b1;
    else       r_vsync_d <= v_sync;
  end
  assign w_tick = v_sync & ~r_vsync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HOLD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      if (aim_detected)    w_state_next = TRACK;
      else if (target_off) w_state_next = SEARCH;
      else                 w_state_next = HOLD;
    end
  end

  always_comb begin
    state_out = r_state;
  end

  assign w_ex     = $signed({1'b0, aim_x}) - L_CX;
  assign w_ey     = $signed({1'b0, aim_y}) - L_CY;
  assign w_db_x   = (abs11(w_ex) <= L_DB);
  assign w_db_y   = (abs11(w_ey) <= L_DB);
  assign w_pan_s  = $signed({2'b00, r_pan});
  assign w_tilt_s = $signed({2'b00, r_tilt});
  assign w_sweep_sum = r_dir_up ? (w_pan_s + L_SWEEP) : (w_pan_s - L_SWEEP);
  assign w_tdiff  = L_CENTER - w_tilt_s;

  always_comb begin
    w_pan_next    = r_pan;
    w_tilt_next   = r_tilt;
    w_dir_up_next = r_dir_up;
    w_on_next     = r_on_target;
    if (w_tick) begin
      w_on_next = (w_state_next == TRACK) && w_db_x && w_db_y;
      case (w_state_next)
        TRACK: begin
          w_pan_next  = track_axis(r_pan, w_ex, PAN_INV);
          w_tilt_next = track_axis(r_tilt, w_ey, TILT_INV);
        end
        SEARCH: begin
          if (r_dir_up && (w_sweep_sum >= L_MAX)) begin
            w_pan_next    = 16'(L_MAX);
            w_dir_up_next = 1'b0;
          end else if (!r_dir_up && (w_sweep_sum <= L_MIN)) begin
            w_pan_next    = 16'(L_MIN);
            w_dir_up_next = 1'b1;
          end else begin
            w_pan_next = 16'(w_sweep_sum);
          end
          // Tilt parks back at centre, rate-limited like tracking.
          if ((w_tdiff <= L_STEP_MAX) && (w_tdiff >= -L_STEP_MAX))
            w_tilt_next = 16'(L_CENTER);
          else if (w_tdiff > 18'sd0)
            w_tilt_next = 16'(w_tilt_s + L_STEP_MAX);
          else
            w_tilt_next = 16'(w_tilt_s - L_STEP_MAX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pan       <= 16'(PULSE_CENTER);
      r_tilt      <= 16'(PULSE_CENTER);
      r_dir_up    <= 1'b1;
      r_on_target <= 1'b0;
    end else begin
      r_pan       <= w_pan_next;
      r_tilt      <= w_tilt_next;
      r_dir_up    <= w_dir_up_next;
      r_on_target <= w_on_next;
    end
  end

  assign pan_pulse  = r_pan;
  assign tilt_pulse = r_tilt;
  assign on_target  = r_on_target;

  // One shared counter so pan and tilt pulses start on the same cycle.
  assign w_wrap = (r_cnt == CNT_W'(PWM_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  servo_pwm_gen #(.CNT_W(CNT_W)) u_pan_pwm (
    .clk     (clk),
    .reset   (reset),
    .i_cnt   (r_cnt),
    .i_wrap  (w_wrap),
    .i_width (r_pan),
    .o_pwm   (pan_pwm)
  );

  servo_pwm_gen #(.CNT_W(CNT_W)) u_tilt_pwm (
    .clk     (clk),
    .reset   (reset),
    .i_cnt   (r_cnt),
    .i_wrap  (w_wrap),
    .i_width (r_tilt),
    .o_pwm   (tilt_pwm)
  );

endmodule

// File: tb/tb_aim_servo_ctrl.sv
// tb/tb_aim_servo_ctrl.sv - scoreboard bench for aim_servo_ctrl with scaled timing
module tb_aim_servo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_sync;
  logic [9:0]  aim_x;
  logic [9:0]  aim_y;
  logic        aim_detected;
  logic        target_off;
  logic        pan_pwm, tilt_pwm;
  logic [15:0] pan_pulse, tilt_pulse;
  logic [1:0]  state_out;
  logic        on_target;
  logic        b_pan_pwm, b_tilt_pwm;
  logic [15:0] b_pan_pulse, b_tilt_pulse;
  logic [1:0]  b_state_out;
  logic        b_on_target;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aim_servo_ctrl #(
    .PWM_PERIOD(1000), .PULSE_MIN(250), .PULSE_MAX(500), .PULSE_CENTER(375),
    .MAX_STEP(50), .SWEEP_STEP(25), .PAN_INV(1'b0), .TILT_INV(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off),
    .pan_pwm(pan_pwm), .tilt_pwm(tilt_pwm), .pan_pulse(pan_pulse),
    .tilt_pulse(tilt_pulse), .state_out(state_out), .on_target(on_target)
  );

  aim_servo_ctrl #(
    .PWM_PERIOD(1000), .PULSE_MIN(250), .PULSE_MAX(500), .PULSE_CENTER(375),
    .MAX_STEP(50), .SWEEP_STEP(25), .PAN_INV(1'b1), .TILT_INV(1'b0)
  ) u_dut_inv (
    .clk(clk), .reset(reset), .v_sync(v_sync), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off),
    .pan_pwm(b_pan_pwm), .tilt_pwm(b_tilt_pwm), .pan_pulse(b_pan_pulse),
    .tilt_pulse(b_tilt_pulse), .state_out(b_state_out), .on_target(b_on_target)
  );

  typedef struct {
    string name;
    int    pan;
    int    tilt;
    int    pan_b;
    int    st;
    int    on;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-tick observer: the DUT commits its new outputs on the edge that sees the tick.
  logic s1 = 1'b0, s2 = 1'b0;
  always @(posedge clk) begin
    s1 <= v_sync;
    s2 <= s1;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s1 && !s2 && !reset) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tick: got frame update, expected none queued");
        end else begin
          e = sb_q.pop_front();
          check({e.name, ".pan"},    32'(pan_pulse),    32'(e.pan));
          check({e.name, ".tilt"},   32'(tilt_pulse),   32'(e.tilt));
          check({e.name, ".pan_b"},  32'(b_pan_pulse),  32'(e.pan_b));
          check({e.name, ".tilt_b"}, 32'(b_tilt_pulse), 32'(e.tilt));
          check({e.name, ".state"},  32'(state_out),    32'(e.st));
          check({e.name, ".on"},     32'(on_target),    32'(e.on));
        end
      end
    end
  end

  task automatic frame(input string nm, input int x, input int y, input bit det, input bit off,
                       input int ep, input int et, input int epb, input int est, input int eon);
    exp_t e;
    e.name = nm; e.pan = ep; e.tilt = et; e.pan_b = epb; e.st = est; e.on = eon;
    sb_q.push_back(e);
    aim_x = 10'(x);
    aim_y = 10'(y);
    aim_detected = det;
    target_off = off;
    v_sync = 1'b1;
    @(negedge clk);
    v_sync = 1'b0;
    aim_x = 10'($urandom);
    aim_y = 10'($urandom);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = pan_pwm;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!prev && pan_pwm) begin
        ok = 1'b1;
        break;
      end
      prev = pan_pwm;
    end
  endtask

  task automatic count_high(output int w);
    w = 1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (pan_pwm) w++;
      else break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hp, ht, w1, w2;
    bit  ok;
    reset = 1'b1; v_sync = 1'b0; aim_x = '0; aim_y = '0;
    aim_detected = 1'b0; target_off = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.pan",   32'(pan_pulse), 32'd375);
    check("rst.tilt",  32'(tilt_pulse), 32'd375);
    check("rst.state", 32'(state_out), 32'd0);
    check("rst.on",    32'(on_target), 32'd0);
    check("rst.pwm",   32'(pan_pwm | tilt_pwm), 32'd0);
    reset = 1'b0;

    repeat (1500) @(negedge clk);
    hp = 0; ht = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pan_pwm) hp++;
      if (tilt_pwm) ht++;
    end
    check("idle.pan_high",  32'(hp), 32'd375);
    check("idle.tilt_high", 32'(ht), 32'd375);

    frame("trk_step",   340, 240, 1, 0, 425, 375, 325, 1, 0);
    frame("trk_db",     330, 250, 1, 0, 425, 375, 325, 1, 1);
    frame("trk_neg",    300, 240, 1, 0, 375, 375, 375, 1, 0);
    frame("sat1",       639, 479, 1, 0, 425, 425, 325, 1, 0);
    frame("sat2",       639, 479, 1, 0, 475, 475, 275, 1, 0);
    frame("sat3",       639, 479, 1, 0, 500, 500, 250, 1, 0);
    frame("sat4",       639, 479, 1, 0, 500, 500, 250, 1, 0);

    wait_rise(ok);
    check("pwm.rise1", 32'(ok), 32'd1);
    fork
      count_high(w1);
      begin
        repeat (100) @(negedge clk);
        frame("mid_period", 0, 479, 1, 0, 450, 500, 300, 1, 0);
      end
    join
    check("pwm.old_width", 32'(w1), 32'd500);
    wait_rise(ok);
    check("pwm.rise2", 32'(ok), 32'd1);
    count_high(w2);
    check("pwm.new_width", 32'(w2), 32'd450);

    frame("hold",       100, 100, 0, 0, 450, 500, 300, 0, 0);
    frame("srch1",        0,   0, 0, 1, 475, 450, 325, 2, 0);
    frame("srch2",        0,   0, 0, 1, 500, 400, 350, 2, 0);
    frame("srch3",        0,   0, 0, 1, 475, 375, 375, 2, 0);
    frame("srch4",        0,   0, 0, 1, 450, 375, 400, 2, 0);
    frame("hold2",        0,   0, 0, 0, 450, 375, 400, 0, 0);
    frame("srch5",        0,   0, 0, 1, 425, 375, 425, 2, 0);
    frame("both",       320, 240, 1, 1, 425, 375, 425, 1, 1);
    frame("srch6",        0,   0, 0, 1, 400, 375, 450, 2, 0);

    reset = 1'b1;
    #1;
    check("rst2.pan",   32'(pan_pulse),   32'd375);
    check("rst2.pan_b", 32'(b_pan_pulse), 32'd375);
    check("rst2.state", 32'(state_out),   32'd0);
    check("rst2.pwm",   32'(pan_pwm),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    frame("srch_after_rst", 0, 0, 0, 1, 400, 375, 400, 2, 0);

    repeat (4) @(negedge clk);
    check("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
